seq_stage_controller: RTL and testbench
=======================================

// Module: seq_stage_controller
// PURPOSE
// - Multi-cycle sequencer for the Y86-64 SEQ datapath (fetch/decode/execute/memory/writeback/PC update).
// - Issues one-hot stage-enable pulses and skips stages an icode does not need.
// - Owns the single shared memory port, granting it to instruction fetch or data access with req/ack.
// - Tracks processor status (AOK/HLT/ADR/INS) and stops the machine on halt or on an error.
// PARAMETERS
// - MEM_TIMEOUT, default 16: max cycles a memory request may wait for mem_ack before ADR.
// - CNT_W, default 32: width of cycle_count and instr_count.
// PORTS
// - clk          in   1      clock; single clock domain, rising edge.
// - rst          in   1      reset, asynchronous, active-high.
// - start        in   1      leave IDLE and begin fetching (sampled in IDLE only).
// - stop         in   1      return to IDLE after the current PCUPD.
// - icode        in   4      opcode from fetch; valid from the DECODE state onward.
// - instr_valid  in   1      fetch decoded a legal icode/ifun.
// - mem_ack      in   1      memory completed the current request this cycle.
// - mem_error    in   1      qualifies mem_ack: bad address.
// - mem_req      out  1      memory request, held until ack, error or timeout.
// - mem_sel      out  1      0 = instruction fetch, 1 = data access.
// - mem_we       out  1      data write (rmmovq, call, pushq); 0 during fetch.
// - f_en, d_en, e_en, m_en, w_en, pc_en  out  1 each  one-cycle stage strobes.
// - cc_we        out  1      condition-code write, icode==6 (OPq), in EXECUTE only.
// - stat         out  2      00 AOK, 01 HLT, 10 ADR, 11 INS.
// - halted       out  1      sticky; set when the machine stops on HLT, ADR or INS.
// - cycle_count  out  CNT_W  active cycles, saturating.
// - instr_count  out  CNT_W  retired instructions, wrapping.
// BEHAVIOUR
// - Reset: async; state=IDLE; every output 0; stat=AOK; counters 0. Mid-request reset drops mem_req immediately.
// - States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
// - All outputs are Moore decodes of the state register plus the same-cycle mem_ack.
// - IDLE: start=1 -> FETCH.
// - FETCH: mem_req=1, mem_sel=0.
//   - mem_ack & !mem_error: f_en=1 -> DECODE.
//   - mem_ack & mem_error: stat=ADR -> HALT.
// - DECODE:
//   - !instr_valid: stat=INS -> HALT.
//   - icode==0: stat=HLT -> HALT, with no pc_en.
//   - otherwise: d_en=1 -> EXECUTE.
// - EXECUTE: e_en=1; cc_we=1 if icode==6. Next state:
//   - MEMORY for icode in {4,5,8,9,A,B};
//   - else WRITEBACK for {2,3,6};
//   - else PCUPD for {1,7}.
// - MEMORY: mem_req=1, mem_sel=1, mem_we=1 for {4,8,A}. Ack/error handling as in FETCH (m_en instead of f_en).
//   - On success -> WRITEBACK for {5,8,9,A,B}, else PCUPD.
// - WRITEBACK: w_en=1 -> PCUPD.
// - PCUPD: pc_en=1; instr_count+=1. stop=1 -> IDLE, else FETCH.
// - HALT: terminal until rst; halted=1; start and stop ignored; no strobes.
// - Timeout: a wait counter clears on entry to FETCH or MEMORY.
//   - Counter reaches MEM_TIMEOUT-1 without ack: stat=ADR -> HALT; mem_req low the next cycle.
//   - Ack in that same cycle wins over the timeout.
// - Latency, zero-wait memory: irmovq 5 cycles, rmmovq 5, mrmovq 6, nop 4.
// - cycle_count increments in every non-IDLE, non-HALT state; holds at all-ones.
// - Exactly one stage strobe at a time; mem_req is never asserted outside FETCH or MEMORY.
// STRUCTURE
// - seq_ctrl_pkg holds: icode constants (HALT..POPQ), stat encodings, state encoding, and needs_mem/needs_wb/mem_write functions.
// - Sub-module seq_mem_timer holds the wait counter and timeout flag (inputs clear and tick).
// TESTING
// - Reset mid-FETCH with mem_req=1 -> mem_req=0 asynchronously; stat=00; counters 0; state IDLE.
// - irmovq (icode=3), ack in the first FETCH cycle:
//   - strobes f,d,e,w,pc on cycles 1..5;
//   - no m_en, no cc_we;
//   - instr_count=1.
// - rmmovq (icode=4), data ack after 3 wait cycles:
//   - MEMORY holds mem_req=1, mem_sel=1, mem_we=1 for 4 cycles;
//   - m_en on the ack cycle;
//   - no w_en.
// - OPq (icode=6) then pushq (icode=A):
//   - cc_we=1 only in OPq's EXECUTE;
//   - pushq asserts mem_we=1 and w_en.
// - MEM_TIMEOUT=16, no ack in FETCH:
//   - on the 16th cycle stat=10, then halted=1 and mem_req=0;
//   - a later start has no effect.
// - Halt and illegal decode:
//   - icode=0 -> stat=01, halted=1, no pc_en;
//   - after rst, instr_valid=0 -> stat=11.
//   - Ack coincident with the timeout cycle -> normal completion, stat=00.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the Y86-64 SEQ stage sequencer.
//   - icode constants (HALT..POPQ)
//   - processor status encodings
//   - controller state encoding (legacy 3-bit constants)
//   - per-icode stage-usage helpers: needs_mem / needs_wb / mem_write
package seq_ctrl_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_e;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_PCUPD     = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  // Instructions that perform a data-memory access.
  function automatic logic needs_mem(input logic [3:0] ic);
    return ic inside {ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
                      ICODE_RET, ICODE_PUSHQ, ICODE_POPQ};
  endfunction

  // Instructions that write the register file (including %rsp updates).
  function automatic logic needs_wb(input logic [3:0] ic);
    return ic inside {ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_MRMOVQ, ICODE_OPQ,
                      ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ};
  endfunction

  // Data accesses that are writes.
  function automatic logic mem_write(input logic [3:0] ic);
    return ic inside {ICODE_RMMOVQ, ICODE_CALL, ICODE_PUSHQ};
  endfunction

endpackage

// File: rtl/seq_stage_controller_if.sv
// Shared memory-port handshake between the SEQ controller and memory.
//   mem_req   controller -> memory  request, held until ack/error/timeout
//   mem_sel   controller -> memory  0 = instruction fetch, 1 = data access
//   mem_we    controller -> memory  data write
//   mem_ack   memory -> controller  request completed this cycle
//   mem_error memory -> controller  qualifies mem_ack: bad address
interface seq_stage_controller_if;
  logic mem_req;
  logic mem_sel;
  logic mem_we;
  logic mem_ack;
  logic mem_error;

  modport master (
    output mem_req, mem_sel, mem_we,
    input  mem_ack, mem_error
  );

  modport slave (
    input  mem_req, mem_sel, mem_we,
    output mem_ack, mem_error
  );
endinterface

// File: rtl/seq_mem_timer.sv
// Memory wait counter. Counts cycles a request has waited without ack and
// flags the last permitted cycle (count == MEM_TIMEOUT-1).
//   clk, rst   clock, async active-high reset
//   clear_i    force count to zero (controller not waiting on memory)
//   tick_i     one more cycle waited without ack
//   timeout_o  current cycle is the last one allowed before ADR
module seq_mem_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic tick_i,
  output logic timeout_o
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout_o = (count_q == LIMIT);

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath.
// Steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/PCUPD, issuing one-hot stage
// strobes, skipping stages an icode does not use, owning the shared memory
// port and tracking processor status.
//   clk, rst                  clock, async active-high reset
//   start                     leave IDLE (sampled in IDLE only)
//   stop                      return to IDLE after the current PCUPD
//   icode, instr_valid        decoded opcode / legality from fetch
//   mem                       shared memory port (master side)
//   f_en..pc_en               one-cycle stage strobes
//   cc_we                     condition-code write (OPq EXECUTE)
//   stat                      00 AOK, 01 HLT, 10 ADR, 11 INS
//   halted                    machine stopped on HLT/ADR/INS
//   cycle_count               active cycles, saturating
//   instr_count               retired instructions, wrapping
module seq_stage_controller
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [3:0]            icode,
  input  logic                  instr_valid,
  seq_stage_controller_if.master mem,
  output logic                  f_en,
  output logic                  d_en,
  output logic                  e_en,
  output logic                  m_en,
  output logic                  w_en,
  output logic                  pc_en,
  output logic                  cc_we,
  output logic [1:0]            stat,
  output logic                  halted,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      instr_count
);

  logic [2:0]       state_q, state_d;
  stat_e            stat_q, stat_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic in_mem;
  logic ack_ok;
  logic timeout;

  assign in_mem = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign ack_ok = mem.mem_ack && !mem.mem_error;

  // Counter is held at zero whenever no memory request is outstanding, so it
  // is already clear on the first cycle of every FETCH/MEMORY visit.
  seq_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!in_mem),
    .tick_i    (in_mem && !mem.mem_ack),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        // An ack in the timeout cycle takes priority over the timeout.
        if (ack_ok) begin
          state_d = S_DECODE;
        end else if (mem.mem_ack || timeout) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == ICODE_HALT) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (needs_mem(icode))     state_d = S_MEMORY;
        else if (needs_wb(icode)) state_d = S_WRITEBACK;
        else                      state_d = S_PCUPD;
      end
      S_MEMORY: begin
        if (ack_ok) begin
          state_d = needs_wb(icode) ? S_WRITEBACK : S_PCUPD;
        end else if (mem.mem_ack || timeout) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD:     state_d = stop ? S_IDLE : S_FETCH;
      default:     state_d = S_HALT;
    endcase
  end

  always_comb begin
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    if ((state_q != S_IDLE) && (state_q != S_HALT) && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + 1'b1;
    end
    if (state_q == S_PCUPD) begin
      instr_count_d = instr_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      stat_q        <= STAT_AOK;
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stat_q        <= stat_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign mem.mem_req = in_mem;
  assign mem.mem_sel = (state_q == S_MEMORY);
  assign mem.mem_we  = (state_q == S_MEMORY) && mem_write(icode);

  assign f_en  = (state_q == S_FETCH) && ack_ok;
  assign d_en  = (state_q == S_DECODE) && instr_valid && (icode != ICODE_HALT);
  assign e_en  = (state_q == S_EXECUTE);
  assign m_en  = (state_q == S_MEMORY) && ack_ok;
  assign w_en  = (state_q == S_WRITEBACK);
  assign pc_en = (state_q == S_PCUPD);
  assign cc_we = (state_q == S_EXECUTE) && (icode == ICODE_OPQ);

  assign stat        = stat_q;
  assign halted      = (state_q == S_HALT);
  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench for seq_stage_controller. Each scenario queues per-cycle
// stimulus together with the expected strobe/memory-port vector derived from
// Y86-64 stage usage; the drain compares one entry per clock cycle.
module tb_seq_stage_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        ack_drv;
  logic        err_drv;

  logic        f_en, d_en, e_en, m_en, w_en, pc_en, cc_we, halted;
  logic [1:0]  stat;
  logic [31:0] cycle_count, instr_count;

  logic        s_f, s_d, s_e, s_m, s_w, s_pc, s_cc, s_halted;
  logic [1:0]  s_stat;
  logic [2:0]  s_cycle, s_instr;

  seq_stage_controller_if mif ();
  seq_stage_controller_if sif ();

  assign mif.mem_ack   = ack_drv;
  assign mif.mem_error = err_drv;
  assign sif.mem_ack   = ack_drv;
  assign sif.mem_error = err_drv;

  seq_stage_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .icode(icode),
    .instr_valid(instr_valid), .mem(mif),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en),
    .pc_en(pc_en), .cc_we(cc_we), .stat(stat), .halted(halted),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  // Narrow-counter copy driven by the same stimulus: exercises saturation
  // of cycle_count and wrap of instr_count.
  seq_stage_controller #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .icode(icode),
    .instr_valid(instr_valid), .mem(sif),
    .f_en(s_f), .d_en(s_d), .e_en(s_e), .m_en(s_m), .w_en(s_w),
    .pc_en(s_pc), .cc_we(s_cc), .stat(s_stat), .halted(s_halted),
    .cycle_count(s_cycle), .instr_count(s_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector bit order: f d e m w pc cc req sel we
  localparam logic [9:0] B_F   = 10'h200;
  localparam logic [9:0] B_D   = 10'h100;
  localparam logic [9:0] B_E   = 10'h080;
  localparam logic [9:0] B_M   = 10'h040;
  localparam logic [9:0] B_W   = 10'h020;
  localparam logic [9:0] B_PC  = 10'h010;
  localparam logic [9:0] B_CC  = 10'h008;
  localparam logic [9:0] B_REQ = 10'h004;
  localparam logic [9:0] B_SEL = 10'h002;
  localparam logic [9:0] B_WE  = 10'h001;

  // Y86-64 stage usage per icode (bit n = icode n).
  logic [15:0] mem_set = 16'h0F30;  // rmmovq mrmovq call ret pushq popq
  logic [15:0] wb_set  = 16'h0F6C;  // rrmovq irmovq mrmovq OPq call ret pushq popq
  logic [15:0] wr_set  = 16'h0510;  // rmmovq call pushq

  typedef struct packed {
    logic       ack;
    logic       err;
    logic       stp;
    logic       vld;
    logic [3:0] ic;
  } stim_t;

  stim_t      stim_q[$];
  logic [9:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cycles;
  int exp_instr;

  task automatic push_cycle(input logic ack, input logic err, input logic stp,
                            input logic vld, input logic [3:0] ic,
                            input logic [9:0] exp);
    stim_t s;
    s.ack = ack; s.err = err; s.stp = stp; s.vld = vld; s.ic = ic;
    stim_q.push_back(s);
    exp_q.push_back(exp);
  endtask

  task automatic push_instr(input logic [3:0] ic, input int fw, input int dw,
                            input logic last);
    logic       um, uw;
    logic [9:0] we;
    um = mem_set[ic];
    uw = wb_set[ic];
    we = wr_set[ic] ? B_WE : 10'h000;
    for (int i = 0; i < fw; i++) push_cycle(1'b0, 1'b0, 1'b0, 1'b1, ic, B_REQ);
    push_cycle(1'b1, 1'b0, 1'b0, 1'b1, ic, B_REQ | B_F);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b1, ic, B_D);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b1, ic, B_E | ((ic == 4'h6) ? B_CC : 10'h000));
    exp_cycles += fw + 3;
    if (um) begin
      for (int i = 0; i < dw; i++) push_cycle(1'b0, 1'b0, 1'b0, 1'b1, ic, B_REQ | B_SEL | we);
      push_cycle(1'b1, 1'b0, 1'b0, 1'b1, ic, B_REQ | B_SEL | we | B_M);
      exp_cycles += dw + 1;
    end
    if (uw) begin
      push_cycle(1'b0, 1'b0, 1'b0, 1'b1, ic, B_W);
      exp_cycles += 1;
    end
    push_cycle(1'b0, 1'b0, last, 1'b1, ic, B_PC);
    exp_cycles += 1;
    exp_instr  += 1;
  endtask

  // Drain: one queued entry per clock, inputs applied mid-cycle, outputs
  // sampled 1ns later (well away from the rising edge).
  task automatic run_queue(input string name);
    stim_t      s;
    logic [9:0] e, o;
    int         cyc;
    cyc = 0;
    while (stim_q.size() > 0) begin
      @(negedge clk);
      s = stim_q.pop_front();
      ack_drv = s.ack; err_drv = s.err; stop = s.stp;
      instr_valid = s.vld; icode = s.ic;
      #1;
      e = exp_q.pop_front();
      o = {f_en, d_en, e_en, m_en, w_en, pc_en, cc_we,
           mif.mem_req, mif.mem_sel, mif.mem_we};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: strobes f,d,e,m,w,pc,cc,req,sel,we = %b, expected %b",
                 name, cyc, o, e);
      end
      cyc++;
    end
    @(negedge clk);
    ack_drv = 1'b0; err_drv = 1'b0; stop = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; stop = 1'b0; ack_drv = 1'b0; err_drv = 1'b0;
    instr_valid = 1'b1; icode = 4'h0;
    rst = 1'b1;
    #2 rst = 1'b0;
    exp_cycles = 0;
    exp_instr  = 0;
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    kick();
    @(negedge clk); #1;
    n_checks++;
    if (mif.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_req: mem_req=%b expected 1", mif.mem_req);
    end
    @(negedge clk); #1;
    n_checks++;
    if (cycle_count !== 32'd1) begin
      n_fail++; $display("FAIL reset_pre_cycles: cycle_count=%0d expected 1", cycle_count);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mif.mem_req, stat, halted, f_en, pc_en} !== 6'b0 ||
        cycle_count !== 32'd0 || instr_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_async: req=%b stat=%b halted=%b cyc=%0d ins=%0d expected all 0",
               mif.mem_req, stat, halted, cycle_count, instr_count);
    end
    #1 rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (mif.mem_req !== 1'b0 || cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_idle: req=%b cyc=%0d expected 0 0", mif.mem_req, cycle_count);
    end
  endtask

  task automatic test_irmovq();
    do_reset();
    kick();
    push_instr(4'h3, 0, 0, 1'b1);
    run_queue("irmovq");
    n_checks++;
    if (instr_count !== 32'(exp_instr) || cycle_count !== 32'(exp_cycles)) begin
      n_fail++;
      $display("FAIL irmovq_counts: ins=%0d cyc=%0d expected %0d %0d",
               instr_count, cycle_count, exp_instr, exp_cycles);
    end
    n_checks++;
    if (s_cycle !== 3'd5 || s_instr !== 3'd1) begin
      n_fail++;
      $display("FAIL irmovq_small: cyc=%0d ins=%0d expected 5 1", s_cycle, s_instr);
    end
  endtask

  task automatic test_rmmovq();
    do_reset();
    kick();
    push_instr(4'h4, 0, 3, 1'b1);
    run_queue("rmmovq");
    n_checks++;
    if (instr_count !== 32'd1 || cycle_count !== 32'(exp_cycles) || stat !== 2'b00) begin
      n_fail++;
      $display("FAIL rmmovq_counts: ins=%0d cyc=%0d stat=%b expected 1 %0d 00",
               instr_count, cycle_count, stat, exp_cycles);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    kick();
    push_instr(4'h6, 1, 0, 1'b0);
    push_instr(4'hA, 0, 1, 1'b0);
    push_instr(4'h5, 0, 0, 1'b0);
    push_instr(4'h1, 0, 0, 1'b0);
    push_instr(4'h8, 2, 0, 1'b0);
    push_instr(4'h9, 0, 2, 1'b0);
    push_instr(4'hB, 0, 0, 1'b0);
    push_instr(4'h7, 0, 0, 1'b0);
    push_instr(4'h2, 0, 0, 1'b1);
    run_queue("back_to_back");
    n_checks++;
    if (instr_count !== 32'(exp_instr) || cycle_count !== 32'(exp_cycles)) begin
      n_fail++;
      $display("FAIL b2b_counts: ins=%0d cyc=%0d expected %0d %0d",
               instr_count, cycle_count, exp_instr, exp_cycles);
    end
    n_checks++;
    if (s_cycle !== 3'd7 || s_instr !== 3'(exp_instr % 8)) begin
      n_fail++;
      $display("FAIL b2b_small_sat_wrap: cyc=%0d ins=%0d expected 7 %0d",
               s_cycle, s_instr, exp_instr % 8);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    kick();
    for (int i = 0; i < 16; i++) push_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h1, B_REQ);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 10'h000);
    run_queue("timeout");
    n_checks++;
    if (stat !== 2'b10 || halted !== 1'b1 || mif.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_stat: stat=%b halted=%b req=%b expected 10 1 0",
               stat, halted, mif.mem_req);
    end
    start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (halted !== 1'b1 || mif.mem_req !== 1'b0 || cycle_count !== 32'd16) begin
      n_fail++;
      $display("FAIL timeout_start_ignored: halted=%b req=%b cyc=%0d expected 1 0 16",
               halted, mif.mem_req, cycle_count);
    end
    start = 1'b0;
  endtask

  task automatic test_halt_illegal();
    do_reset();
    kick();
    push_cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, B_REQ | B_F);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 10'h000);
    push_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 10'h000);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 10'h000);
    run_queue("halt");
    n_checks++;
    if (stat !== 2'b01 || halted !== 1'b1 || instr_count !== 32'd0) begin
      n_fail++;
      $display("FAIL halt_stat: stat=%b halted=%b ins=%0d expected 01 1 0",
               stat, halted, instr_count);
    end

    do_reset();
    kick();
    push_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, B_REQ | B_F);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 10'h000);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 10'h000);
    run_queue("illegal");
    n_checks++;
    if (stat !== 2'b11 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_stat: stat=%b halted=%b expected 11 1", stat, halted);
    end

    do_reset();
    kick();
    push_cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, B_REQ | B_F);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, B_D);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, B_E);
    push_cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'h5, B_REQ | B_SEL);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 10'h000);
    run_queue("data_error");
    n_checks++;
    if (stat !== 2'b10 || halted !== 1'b1 || instr_count !== 32'd0) begin
      n_fail++;
      $display("FAIL data_error_stat: stat=%b halted=%b ins=%0d expected 10 1 0",
               stat, halted, instr_count);
    end
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    kick();
    push_instr(4'h1, 15, 0, 1'b0);
    push_instr(4'h5, 0, 15, 1'b1);
    run_queue("ack_at_timeout");
    n_checks++;
    if (stat !== 2'b00 || halted !== 1'b0 || instr_count !== 32'd2 ||
        cycle_count !== 32'(exp_cycles)) begin
      n_fail++;
      $display("FAIL ack_at_timeout_stat: stat=%b halted=%b ins=%0d cyc=%0d expected 00 0 2 %0d",
               stat, halted, instr_count, cycle_count, exp_cycles);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; icode = 4'h0;
    instr_valid = 1'b1; ack_drv = 1'b0; err_drv = 1'b0;
    exp_cycles = 0; exp_instr = 0;
    test_reset();
    test_irmovq();
    test_rmmovq();
    test_back_to_back();
    test_timeout();
    test_halt_illegal();
    test_ack_at_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
